// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mips_pkg : shared fetch-path constants, FIFO entry type, FSM states
// Rev 1.0
// ----------------------------------------------------------------------
package mips_pkg;

   localparam int              XLEN             = 32;
   localparam int              PC_STEP          = 4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } ifb_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] ins;
   } ifb_entry_t;

   // Sequential word address; wraps modulo 2^XLEN by construction.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(PC_STEP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_buffer_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// instr_fetch_buffer_if : imem request/response and decode-side handshakes
// Rev 1.0
// ----------------------------------------------------------------------
interface instr_fetch_buffer_if;
   import mips_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_ins;
   logic [XLEN-1:0] out_pc;

   // master = fetch buffer side, slave = memory/decode environment side
   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_ins, out_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_ins, out_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );

endinterface
`default_nettype wire

// File: rtl/ifb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// ifb_fifo : synchronous DEPTH x {pc, ins} FIFO with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------
module ifb_fifo
   import mips_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  wire logic               clk,
   input  wire logic               clr,
   input  wire logic               i_flush,
   input  wire logic               i_push,
   input  wire ifb_entry_t         i_wdata,
   input  wire logic               i_pop,
   output ifb_entry_t              o_rdata,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam ifb_entry_t c_RST_ENTRY = '{pc: RESET_PC, ins: '0};

   ifb_entry_t       r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Storage is cleared so the head reads {RESET_PC, 0} straight out of reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= c_RST_ENTRY;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------
// instr_fetch_buffer : credit-limited instruction prefetch with redirect flush
// Rev 1.0 | optional macro IFB_BYPASS_EN: same-cycle response bypass
// ----------------------------------------------------------------------
module instr_fetch_buffer
   import mips_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  wire logic            clk,
   input  wire logic            clr,
   input  wire logic            redirect,
   input  wire logic [XLEN-1:0] redirect_pc,
   instr_fetch_buffer_if.master bus
);
   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW:0] c_DEPTH = (CW+1)'(DEPTH);

   ifb_state_t       r_state;
   logic [XLEN-1:0]  r_fetch_pc;
   logic [XLEN-1:0]  r_rsp_pc;
   logic [CW-1:0]    r_outstanding;
   logic [CW-1:0]    r_drop_cnt;

   logic [CW-1:0]    w_fifo_count;
   logic             w_fifo_empty;
   ifb_entry_t       w_head;
   ifb_entry_t       w_wr_entry;
   ifb_entry_t       w_out_entry;
   logic [CW:0]      w_inflight;
   logic [CW-1:0]    w_rsp_dec;
   logic [CW-1:0]    w_drop_load;
   logic             w_req_valid;
   logic             w_req_hs;
   logic             w_keep;
   logic             w_push;
   logic             w_pop;
   logic             w_out_valid;

   always_comb begin
      // Queued plus in-flight words never exceed DEPTH, so no response can hit a full FIFO.
      w_inflight     = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
      w_req_valid    = !clr && !redirect && (w_inflight < c_DEPTH);
      w_req_hs       = w_req_valid && bus.imem_req_ready;
      w_rsp_dec      = CW'(bus.imem_rsp_valid);
      w_drop_load    = r_outstanding - w_rsp_dec;
      w_keep         = bus.imem_rsp_valid && !redirect && (r_state == ST_RUN);
      w_wr_entry.pc  = r_rsp_pc;
      w_wr_entry.ins = bus.imem_rsp_data;
`ifdef IFB_BYPASS_EN
      w_out_valid    = !clr && !redirect && (!w_fifo_empty || w_keep);
      w_out_entry    = (w_fifo_empty && w_keep) ? w_wr_entry : w_head;
      w_push         = w_keep && !(w_fifo_empty && bus.out_ready);
`else
      w_out_valid    = !clr && !redirect && !w_fifo_empty;
      w_out_entry    = w_head;
      w_push         = w_keep;
`endif
      w_pop          = w_out_valid && bus.out_ready && !w_fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state       <= ST_RUN;
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else if (redirect) begin
         // A response landing with the redirect is already stale and is not counted.
         r_fetch_pc    <= redirect_pc;
         r_rsp_pc      <= redirect_pc;
         r_outstanding <= w_drop_load;
         r_drop_cnt    <= w_drop_load;
         r_state       <= (w_drop_load != '0) ? ST_FLUSH : ST_RUN;
      end else begin
         if (w_req_hs) begin
            r_fetch_pc <= next_pc(r_fetch_pc);
         end
         if (w_keep) begin
            r_rsp_pc <= next_pc(r_rsp_pc);
         end
         r_outstanding <= r_outstanding + CW'(w_req_hs) - w_rsp_dec;
         case (r_state)
            ST_RUN: begin
               r_state <= ST_RUN;
            end
            ST_FLUSH: begin
               if (bus.imem_rsp_valid) begin
                  r_drop_cnt <= r_drop_cnt - CW'(1);
                  if (r_drop_cnt == CW'(1)) begin
                     r_state <= ST_RUN;
                  end
               end
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   ifb_fifo #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) u_fifo (
      .clk      (clk),
      .clr      (clr),
      .i_flush  (redirect),
      .i_push   (w_push),
      .i_wdata  (w_wr_entry),
      .i_pop    (w_pop),
      .o_rdata  (w_head),
      .o_count  (w_fifo_count),
      .o_empty  (w_fifo_empty)
   );

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_ins        = w_out_entry.ins;
   assign bus.out_pc         = w_out_entry.pc;

endmodule
`default_nettype wire
